// File: rtl/macrow_out_buf.sv
// macrow_out_buf: first-word-fall-through result FIFO for one MAC row, with sticky overflow flag.
// Optional build macro MACROW_OUT_RELU_EN applies FP16 ReLU to entries on write; NaN is passed through.
module macrow_out_buf #(
    parameter int DEPTH = 8,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          valid_i,
    input  logic [15:0]   Y_i,
    input  logic          clr_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [15:0]   Y_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o,
    output logic          ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [CW-1:0] count, cnt_nxt;
    logic [15:0]   y_q, din;
    logic          ovf, push, pop;

    assign empty_o = (count == '0);
    assign full_o  = (count == CW'(DEPTH));
    assign valid_o = !empty_o;
    assign count_o = count;
    assign ovf_o   = ovf;
    assign Y_o     = y_q;

    // Handshake decode, next read pointer / count, and write-data conditioning.
    always_comb begin
        pop     = valid_o && ready_i;
        push    = valid_i && (!full_o || pop);
        rd_nxt  = pop ? rd_ptr + AW'(1) : rd_ptr;
        cnt_nxt = count + CW'(push) - CW'(pop);
`ifdef MACROW_OUT_RELU_EN
        din     = (Y_i[15] && !(&Y_i[14:10] && |Y_i[9:0])) ? 16'h0000 : Y_i;
`else
        din     = Y_i;
`endif
    end

    // Pointer, count, overflow and registered head; the head is taken from the incoming word when it becomes the oldest entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            y_q    <= 16'h0000;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd_nxt;
            count  <= cnt_nxt;
            ovf    <= ovf || (valid_i && !push);
            if (cnt_nxt != '0)
                y_q <= (push && wr_ptr == rd_nxt) ? din : mem[rd_nxt];
        end
    end

    // Storage array; contents need no reset because the head register masks them.
    always_ff @(posedge clk) begin
        if (push && !clr_i)
            mem[wr_ptr] <= din;
    end
endmodule

// File: tb/tb_macrow_out_buf.sv
// tb_macrow_out_buf: scoreboard bench for macrow_out_buf.
module tb_macrow_out_buf;
    logic        clk = 1'b0;
    logic        reset_n, valid_i, clr_i, ready_i;
    logic [15:0] Y_i;
    logic        valid_o, full_o, empty_o, ovf_o;
    logic [15:0] Y_o;
    logic [3:0]  count_o;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb[$];

    macrow_out_buf #(.DEPTH(8), .CW(4)) dut (
        .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .Y_i(Y_i), .clr_i(clr_i),
        .ready_i(ready_i), .valid_o(valid_o), .Y_o(Y_o), .full_o(full_o),
        .empty_o(empty_o), .count_o(count_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; valid_i = 1'b0; clr_i = 1'b0; ready_i = 1'b0; Y_i = 16'h0;
        #12;
        tests++;
        if ({valid_o, empty_o, full_o, ovf_o, count_o, Y_o} !== {1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 16'h0000}) begin
            fails++;
            $display("FAIL reset: valid=%b empty=%b full=%b ovf=%b count=%0d Y=%h, want 0 1 0 0 0 0000",
                     valid_o, empty_o, full_o, ovf_o, count_o, Y_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        valid_i = 1'b1; Y_i = 16'h4248; sb.push_back(16'h4248);
        tick;
        valid_i = 1'b0;
        tests++;
        if ({valid_o, empty_o, count_o, Y_o} !== {1'b1, 1'b0, 4'd1, 16'h4248}) begin
            fails++;
            $display("FAIL single: valid=%b empty=%b count=%0d Y=%h, want 1 0 1 4248", valid_o, empty_o, count_o, Y_o);
        end
        ready_i = 1'b1;
        while (sb.size() > 0) begin
            tests++;
            if (valid_o !== 1'b1 || Y_o !== sb[0]) begin
                fails++;
                $display("FAIL single_pop: valid=%b Y=%h, want 1 %h", valid_o, Y_o, sb[0]);
            end
            void'(sb.pop_front());
            tick;
        end
        ready_i = 1'b0;
        tests++;
        if (empty_o !== 1'b1 || count_o !== 4'd0) begin
            fails++;
            $display("FAIL single_empty: empty=%b count=%0d, want 1 0", empty_o, count_o);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 9; i++) begin
            valid_i = 1'b1; Y_i = 16'h3C00 + 16'(i);
            if (i < 8) sb.push_back(Y_i);
            tick;
            if (i == 7) begin
                tests++;
                if (full_o !== 1'b1 || count_o !== 4'd8 || ovf_o !== 1'b0) begin
                    fails++;
                    $display("FAIL ovf_full: full=%b count=%0d ovf=%b, want 1 8 0", full_o, count_o, ovf_o);
                end
            end
        end
        valid_i = 1'b0;
        tests++;
        if (ovf_o !== 1'b1 || count_o !== 4'd8) begin
            fails++;
            $display("FAIL ovf_drop: ovf=%b count=%0d, want 1 8", ovf_o, count_o);
        end
        ready_i = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            tests++;
            if (valid_o !== 1'b1 || Y_o !== sb[0]) begin
                fails++;
                $display("FAIL ovf_pop: valid=%b Y=%h, want 1 %h", valid_o, Y_o, sb[0]);
            end
            void'(sb.pop_front());
            tick;
        end
        tests++;
        if (empty_o !== 1'b1 || ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: empty=%b ovf=%b, want 1 1", empty_o, ovf_o);
        end
        tick;
        tests++;
        if (count_o !== 4'd0 || valid_o !== 1'b0) begin
            fails++;
            $display("FAIL empty_ready: count=%0d valid=%b, want 0 0", count_o, valid_o);
        end
        ready_i = 1'b0;
        clr_i = 1'b1;
        tick;
        clr_i = 1'b0;
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 8; i++) begin
            valid_i = 1'b1; Y_i = 16'h1000 + 16'(i); sb.push_back(Y_i);
            tick;
        end
        valid_i = 1'b1; Y_i = 16'h7BFF; ready_i = 1'b1;
        tests++;
        if (full_o !== 1'b1 || Y_o !== sb[0]) begin
            fails++;
            $display("FAIL fpp_head: full=%b Y=%h, want 1 %h", full_o, Y_o, sb[0]);
        end
        void'(sb.pop_front());
        sb.push_back(16'h7BFF);
        tick;
        valid_i = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            if (k == 0) begin
                tests++;
                if (count_o !== 4'd8 || ovf_o !== 1'b0) begin
                    fails++;
                    $display("FAIL fpp_count: count=%0d ovf=%b, want 8 0", count_o, ovf_o);
                end
            end
            tests++;
            if (valid_o !== 1'b1 || Y_o !== sb[0]) begin
                fails++;
                $display("FAIL fpp_pop: valid=%b Y=%h, want 1 %h", valid_o, Y_o, sb[0]);
            end
            void'(sb.pop_front());
            tick;
        end
        ready_i = 1'b0;
    endtask

    task automatic test_relu;
        logic [15:0] in_v [4];
        logic [15:0] ex_v [4];
        in_v = '{16'hD468, 16'h8000, 16'hFE01, 16'h2A66};
`ifdef MACROW_OUT_RELU_EN
        ex_v = '{16'h0000, 16'h0000, 16'hFE01, 16'h2A66};
`else
        ex_v = '{16'hD468, 16'h8000, 16'hFE01, 16'h2A66};
`endif
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1; Y_i = in_v[i]; sb.push_back(ex_v[i]);
            tick;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            tests++;
            if (valid_o !== 1'b1 || Y_o !== sb[0]) begin
                fails++;
                $display("FAIL relu_pop: valid=%b Y=%h, want 1 %h", valid_o, Y_o, sb[0]);
            end
            void'(sb.pop_front());
            tick;
        end
        ready_i = 1'b0;
    endtask

    task automatic test_clr;
        for (int i = 0; i < 9; i++) begin
            valid_i = 1'b1; Y_i = 16'h2000 + 16'(i);
            if (i < 8) sb.push_back(Y_i);
            tick;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (Y_o !== sb[0]) begin
                fails++;
                $display("FAIL clr_prepop: Y=%h, want %h", Y_o, sb[0]);
            end
            void'(sb.pop_front());
            tick;
        end
        ready_i = 1'b0;
        tests++;
        if (count_o !== 4'd3 || ovf_o !== 1'b1) begin
            fails++;
            $display("FAIL clr_pre: count=%0d ovf=%b, want 3 1", count_o, ovf_o);
        end
        clr_i = 1'b1; valid_i = 1'b1; Y_i = 16'h5555;
        tick;
        clr_i = 1'b0; valid_i = 1'b0;
        sb.delete();
        tests++;
        if ({count_o, empty_o, ovf_o, valid_o} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL clr: count=%0d empty=%b ovf=%b valid=%b, want 0 1 0 0", count_o, empty_o, ovf_o, valid_o);
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; Y_i = 16'h6000 + 16'(i);
            tick;
        end
        valid_i = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        tests++;
        if ({valid_o, count_o, empty_o, Y_o} !== {1'b0, 4'd0, 1'b1, 16'h0000}) begin
            fails++;
            $display("FAIL async_reset: valid=%b count=%0d empty=%b Y=%h, want 0 0 1 0000", valid_o, count_o, empty_o, Y_o);
        end
        @(negedge clk);
        reset_n = 1'b1;
        valid_i = 1'b1; Y_i = 16'h0ABC; sb.push_back(16'h0ABC);
        tick;
        valid_i = 1'b0;
        tests++;
        if (count_o !== 4'd1 || Y_o !== sb[0]) begin
            fails++;
            $display("FAIL post_reset: count=%0d Y=%h, want 1 %h", count_o, Y_o, sb[0]);
        end
        void'(sb.pop_front());
        ready_i = 1'b1;
        tick;
        ready_i = 1'b0;
    endtask

    task automatic test_stream;
        for (int i = 0; i < 3; i++) begin
            valid_i = 1'b1; Y_i = 16'h4000 + 16'(i); sb.push_back(Y_i);
            tick;
        end
        ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            Y_i = 16'h5000 + 16'(i);
            tests++;
            if (valid_o !== 1'b1 || Y_o !== sb[0] || count_o !== 4'd3) begin
                fails++;
                $display("FAIL stream: valid=%b Y=%h count=%0d, want 1 %h 3", valid_o, Y_o, count_o, sb[0]);
            end
            void'(sb.pop_front());
            sb.push_back(Y_i);
            tick;
        end
        valid_i = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            tests++;
            if (valid_o !== 1'b1 || Y_o !== sb[0]) begin
                fails++;
                $display("FAIL stream_drain: valid=%b Y=%h, want 1 %h", valid_o, Y_o, sb[0]);
            end
            void'(sb.pop_front());
            tick;
        end
        ready_i = 1'b0;
        tests++;
        if (empty_o !== 1'b1) begin
            fails++;
            $display("FAIL stream_empty: empty=%b, want 1", empty_o);
        end
    endtask

    initial begin
        test_reset;
        test_single;
        test_overflow;
        test_full_push_pop;
        test_relu;
        test_clr;
        test_async_reset;
        test_stream;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/macrow_out_buf.md
MACROW_OUT_BUF -- requirements
Module: macrow_out_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, minimum 2.
REQ-002 SHALL have parameter CW, default 4, width of count_o; must equal log2(DEPTH)+1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port valid_i  input  1  result strobe from the upstream MAC row.
REQ-006 SHALL have port Y_i  input  16  FP16 result from the upstream MAC row, qualified by valid_i.
REQ-007 SHALL have port clr_i  input  1  synchronous clear of FIFO contents and ovf_o.
REQ-008 SHALL have port ready_i  input  1  downstream accepts the head entry when ready_i and valid_o are both 1.
REQ-009 SHALL have port valid_o  output  1  head entry present.
REQ-010 SHALL have port Y_o  output  16  FP16 head entry.
REQ-011 SHALL have port full_o  output  1  count equals DEPTH.
REQ-012 SHALL have port empty_o  output  1  count equals 0.
REQ-013 SHALL have port count_o  output  CW  number of stored entries, 0..DEPTH.
REQ-014 SHALL have port ovf_o  output  1  sticky flag: at least one result dropped.

Function
REQ-015 SHALL be a first-word-fall-through FIFO: Y_o always shows the oldest entry while valid_o=1.
REQ-016 Push SHALL occur when valid_i=1 and (full_o=0, or a pop occurs in the same cycle).
REQ-017 Pop SHALL occur when valid_o=1 and ready_i=1.
REQ-018 Latency: a push in cycle N into an empty FIFO SHALL give valid_o=1 with that data in cycle N+1; there is no bypass in cycle N.
REQ-019 Simultaneous push and pop SHALL leave count unchanged, including when full and when count is 1.
REQ-020 valid_i=1 while full_o=1 and no pop SHALL drop Y_i, leave the contents unchanged, and set ovf_o from cycle N+1.
REQ-021 ready_i=1 while empty_o=1 SHALL be ignored; pointers and count SHALL be unchanged.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; count_o SHALL never exceed DEPTH or underflow.
REQ-023 clr_i=1 SHALL empty the FIFO and clear ovf_o at the next edge.
REQ-024 When clr_i=1, clr_i SHALL take priority over a simultaneous push or pop in the same cycle.
REQ-025 valid_o SHALL equal !empty_o.
REQ-026 full_o, empty_o and count_o SHALL be registered-state derived, not combinational from inputs.
REQ-027 Y_o SHALL hold its last value while valid_o=0; its content in that state is don't-care but must not be X after reset.

Reset
REQ-028 Asserting reset_n low SHALL immediately force pointers=0, count_o=0, empty_o=1, full_o=0, valid_o=0, ovf_o=0 and Y_o=16'h0000.
REQ-029 Asserting reset_n low mid-stream SHALL discard all stored entries.
REQ-030 The first push SHALL be accepted on the first rising edge with reset_n high.

Configuration
REQ-031 With macro MACROW_OUT_RELU_EN defined, entries SHALL be written after FP16 ReLU: sign=1 with any non-NaN value (including -0 and -inf) becomes 16'h0000.
REQ-032 With MACROW_OUT_RELU_EN defined, NaN (exp=5'h1F, mantissa nonzero) SHALL pass unchanged, and positive values SHALL pass unchanged.
REQ-033 With MACROW_OUT_RELU_EN undefined, Y_i SHALL be stored bit-exact; latency and flags SHALL be identical in both builds.

Verification
REQ-034 Reset, then push 16'h4248 with ready_i=0 -> next cycle valid_o=1, Y_o=16'h4248, count_o=1, empty_o=0.
REQ-035 Push 9 values 16'h3C00..16'h3C08 with ready_i=0 -> full_o=1 after the 8th; the 9th is dropped; ovf_o=1; popping yields 16'h3C00..16'h3C07 in order.
REQ-036 Full FIFO, valid_i=1 with 16'h7BFF and ready_i=1 in the same cycle -> count_o stays 8, ovf_o stays 0, 16'h7BFF is the last entry popped.
REQ-037 Build with MACROW_OUT_RELU_EN, push 16'hD468, 16'h8000, 16'hFE01, 16'h2A66 -> popped values 16'h0000, 16'h0000, 16'hFE01, 16'h2A66; without the macro, all four are popped unchanged.
REQ-038 Three entries stored and ovf_o=1, pulse clr_i together with valid_i=1 -> next cycle count_o=0, empty_o=1, ovf_o=0.
REQ-039 Three entries stored, drop reset_n low between clock edges -> valid_o=0 and count_o=0 immediately, before the next edge.
REQ-040 Continuous push and pop for 20 cycles -> pointers wrap correctly and output order matches input order.
